// File: rtl/dport_pkg.sv
// Shared definitions for the data-port responder: size codes, FSM states
// and the size-to-byte-count helper.
package dport_pkg;

  localparam logic [1:0] DSIZ_B = 2'b00;
  localparam logic [1:0] DSIZ_H = 2'b01;
  localparam logic [1:0] DSIZ_W = 2'b10;
  localparam logic [1:0] DSIZ_D = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  // Number of bytes moved by an access of the given size code.
  function automatic logic [3:0] size_bytes(input logic [1:0] dsiz);
    return 4'd1 << dsiz;
  endfunction

endpackage

// File: rtl/dport_lane_align.sv
// Little-endian lane steering between a 64-bit memory line and the
// right-justified bus data, plus the natural-alignment check.
module dport_lane_align
  import dport_pkg::*;
(
  input  logic [2:0]  off,
  input  logic [1:0]  siz,
  input  logic        sgn,
  input  logic [63:0] line,
  input  logic [63:0] wdata,
  output logic [7:0]  mask,
  output logic [63:0] wline,
  output logic [63:0] rdata,
  output logic        misalign
);

  logic [5:0]  bit_off;
  logic [63:0] shifted;
  logic [7:0]  base_mask;

  // Build the byte mask, shift store data into its lanes and extract/extend load data.
  always_comb begin
    bit_off   = {off, 3'b000};
    base_mask = 8'((9'd1 << size_bytes(siz)) - 9'd1);
    mask      = base_mask << off;
    wline     = wdata << bit_off;
    shifted   = line >> bit_off;
    misalign  = (({1'b0, off}) & (size_bytes(siz) - 4'd1)) != 4'd0;
    case (siz)
      DSIZ_B:  rdata = sgn ? {{56{shifted[7]}}, shifted[7:0]}   : {56'd0, shifted[7:0]};
      DSIZ_H:  rdata = sgn ? {{48{shifted[15]}}, shifted[15:0]} : {48'd0, shifted[15:0]};
      DSIZ_W:  rdata = sgn ? {{32{shifted[31]}}, shifted[31:0]} : {32'd0, shifted[31:0]};
      default: rdata = shifted;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Scratch data RAM answering the CPU D port: latches one request, waits a
// fixed number of cycles, then acks for one cycle with load data or error.
module dmem_responder #(
  parameter int AW   = 12,
  parameter int WAIT = 0
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        dcyc_i,
  input  logic        dstb_i,
  input  logic        dwe_i,
  input  logic [63:0] dadr_i,
  input  logic [1:0]  dsiz_i,
  input  logic        dsigned_i,
  input  logic [63:0] ddat_i,
  output logic        dack_o,
  output logic [63:0] ddat_o,
  output logic        derr_o
);
  import dport_pkg::*;

  localparam int         LINES   = 1 << (AW - 3);
  localparam logic [3:0] WAIT_M1 = 4'((WAIT > 0) ? WAIT - 1 : 0);

  logic [63:0] mem [LINES];

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] req_adr;
  logic [1:0]  req_siz;
  logic        req_sgn;
  logic        req_we;
  logic [63:0] req_wdat;
  logic [63:0] line_q;

  logic        req;
  logic        accept;
  logic [7:0]  mask;
  logic [63:0] wline;
  logic [63:0] ld_val;
  logic        misalign;
  logic        out_of_range;
  logic        rejected;

  assign req    = dcyc_i & dstb_i;
  assign accept = (state_q == IDLE) & req;

  dport_lane_align u_align (
    .off      (req_adr[2:0]),
    .siz      (req_siz),
    .sgn      (req_sgn),
    .line     (line_q),
    .wdata    (req_wdat),
    .mask     (mask),
    .wline    (wline),
    .rdata    (ld_val),
    .misalign (misalign)
  );

  assign out_of_range = |req_adr[63:AW];
  assign rejected     = misalign | out_of_range;

  // Outputs decode only from state and latched registers.
  assign dack_o = (state_q == ACK);
  assign derr_o = dack_o & rejected;
  assign ddat_o = (dack_o & ~rejected & ~req_we) ? ld_val : 64'd0;

  // State and wait counter registers.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: accept, count wait states, abort on dropped request, ack once.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (WAIT == 0) begin
            state_d = ACK;
          end else begin
            state_d = dport_pkg::WAIT;
            cnt_d   = WAIT_M1;
          end
        end
      end
      dport_pkg::WAIT: begin
        if (!req) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture the request and read its memory line when a transfer is accepted.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      req_adr  <= 64'd0;
      req_siz  <= 2'd0;
      req_sgn  <= 1'b0;
      req_we   <= 1'b0;
      req_wdat <= 64'd0;
      line_q   <= 64'd0;
    end else if (accept) begin
      req_adr  <= dadr_i;
      req_siz  <= dsiz_i;
      req_sgn  <= dsigned_i;
      req_we   <= dwe_i;
      req_wdat <= ddat_i;
      line_q   <= mem[dadr_i[AW-1:3]];
    end
  end

  // Commit an accepted store on the edge leaving ACK, masked bytes only.
  always_ff @(posedge clk_i) begin
    if (state_q == ACK && req_we && !rejected) begin
      for (int b = 0; b < 8; b++) begin
        if (mask[b]) mem[req_adr[AW-1:3]][8*b +: 8] <= wline[8*b +: 8];
      end
    end
  end

endmodule
